// File: rtl/addsub_result_acc.sv
// Frame accumulator for signed add/sub results with a valid/ready output stage.
// Define ADDSUB_ACC_SAT_EN to clamp the sum on overflow instead of wrapping.
module addsub_result_acc #(
    parameter int DATA_SIZE = 15,
    parameter int CNT_W     = 8,
    parameter int ACC_W     = DATA_SIZE + 9
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [DATA_SIZE:0] in_data,
    input  logic [CNT_W-1:0]        frame_len,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [ACC_W-1:0] out_data,
    output logic                    out_ovf
);

    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

    state_t                  state;
    logic signed [ACC_W-1:0] acc;
    logic [CNT_W-1:0]        cnt;
    logic [CNT_W-1:0]        len_q;
    logic                    ovf_q;

    logic                    accept;
    logic                    first;
    logic [CNT_W-1:0]        len_eff;
    logic [CNT_W-1:0]        cnt_next;
    logic [CNT_W-1:0]        len_next;
    logic                    done;
    logic signed [ACC_W-1:0] base;
    logic [ACC_W:0]          sum;
    logic                    ovf_now;
    logic signed [ACC_W-1:0] acc_next;

    // HOLD passes back-pressure straight through so a new frame can start in the handshake cycle
    always_comb begin
        in_ready = (state == HOLD) ? out_ready : 1'b1;
        accept   = in_valid & in_ready;
        first    = accept & (state != ACCUM);
        len_eff  = (frame_len == '0) ? CNT_W'(1) : frame_len;
        cnt_next = first ? CNT_W'(1) : cnt + CNT_W'(1);
        len_next = first ? len_eff : len_q;
        done     = (cnt_next == len_next);
    end

    // Sum one bit wider than the accumulator; the top two bits disagreeing means overflow
    always_comb begin
        base     = first ? '0 : acc;
        sum      = {base[ACC_W-1], base}
                 + {{(ACC_W - DATA_SIZE){in_data[DATA_SIZE]}}, in_data};
        ovf_now  = sum[ACC_W] ^ sum[ACC_W-1];
        acc_next = sum[ACC_W-1:0];
`ifdef ADDSUB_ACC_SAT_EN
        if (ovf_now) begin
            acc_next = sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            acc       <= '0;
            cnt       <= '0;
            len_q     <= '0;
            ovf_q     <= 1'b0;
            out_valid <= 1'b0;
        end else if (accept) begin
            acc       <= acc_next;
            cnt       <= cnt_next;
            len_q     <= len_next;
            ovf_q     <= first ? ovf_now : (ovf_q | ovf_now);
            state     <= done ? HOLD : ACCUM;
            out_valid <= done;
        end else if (state == HOLD && out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
        end
    end

    assign out_data = acc;
    assign out_ovf  = ovf_q;

endmodule

// File: tb/tb_addsub_result_acc.sv
// Directed bench for addsub_result_acc using a narrowed 17-bit accumulator and an output scoreboard.
// Honours ADDSUB_ACC_SAT_EN the same way as the design.
module tb_addsub_result_acc;

    localparam int DATA_SIZE = 15;
    localparam int CNT_W     = 8;
    localparam int ACC_W     = 17;
    localparam longint ACC_MAX  = (longint'(1) <<< (ACC_W - 1)) - 1;
    localparam longint ACC_MIN  = -(longint'(1) <<< (ACC_W - 1));
    localparam longint ACC_SPAN = longint'(1) <<< ACC_W;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     in_valid;
    logic                     in_ready;
    logic signed [DATA_SIZE:0] in_data;
    logic [CNT_W-1:0]         frame_len;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [ACC_W-1:0]  out_data;
    logic                     out_ovf;

    int total = 0;
    int bad   = 0;

    longint mAcc;
    bit     mOvf;
    logic [ACC_W:0] expQ[$];

    addsub_result_acc #(
        .DATA_SIZE(DATA_SIZE),
        .CNT_W    (CNT_W),
        .ACC_W    (ACC_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .frame_len(frame_len),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_ovf  (out_ovf)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [ACC_W-1:0] observed,
                               input logic [ACC_W-1:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input bit v, input longint d, input int flen, input bit ordy);
        in_valid  = v;
        in_data   = (DATA_SIZE+1)'(d);
        frame_len = CNT_W'(flen);
        out_ready = ordy;
        tick();
    endtask

    // Reference accumulation in plain integer arithmetic
    task automatic modelAccept(input bit first, input longint v);
        longint s;
        s = (first ? 0 : mAcc) + v;
        if (first) mOvf = 1'b0;
        if (s > ACC_MAX) begin
            mOvf = 1'b1;
`ifdef ADDSUB_ACC_SAT_EN
            s = ACC_MAX;
`else
            s = s - ACC_SPAN;
`endif
        end else if (s < ACC_MIN) begin
            mOvf = 1'b1;
`ifdef ADDSUB_ACC_SAT_EN
            s = ACC_MIN;
`else
            s = s + ACC_SPAN;
`endif
        end
        mAcc = s;
    endtask

    function automatic logic [ACC_W-1:0] toBits(input longint v);
        return v[ACC_W-1:0];
    endfunction

    task automatic pushExpected();
        expQ.push_back({mOvf, toBits(mAcc)});
    endtask

    // Every completed output handshake is matched against the oldest expected frame
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpected_out", 1'b1, 1'b0);
            end else begin
                logic [ACC_W:0] e;
                e = expQ.pop_front();
                checkOutput("sb_data", out_data, e[ACC_W-1:0]);
                checkOutput("sb_ovf", out_ovf, e[ACC_W]);
            end
        end
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; frame_len = '0; out_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
        checkOutput("rst_out_valid", out_valid, 1'b0);
        checkOutput("rst_out_data", out_data, '0);
        checkOutput("rst_out_ovf", out_ovf, 1'b0);
        checkOutput("rst_in_ready", in_ready, 1'b1);

        $display("[TB] basic frame of 4");
        modelAccept(1, 10); applyStimulus(1, 10, 4, 1);
        modelAccept(0, -3); applyStimulus(1, -3, 4, 1);
        modelAccept(0, 7);  applyStimulus(1, 7, 4, 1);
        modelAccept(0, 1);  pushExpected(); applyStimulus(1, 1, 4, 1);
        in_valid = 1'b0;
        checkOutput("f4_valid", out_valid, 1'b1);
        checkOutput("f4_data", out_data, toBits(15));
        checkOutput("f4_ovf", out_ovf, 1'b0);
        tick();
        checkOutput("f4_idle", out_valid, 1'b0);

        $display("[TB] back-pressure then zero-bubble restart");
        modelAccept(1, 100); applyStimulus(1, 100, 2, 0);
        modelAccept(0, -40); pushExpected(); applyStimulus(1, -40, 2, 0);
        in_data = 16'sd55;
        for (int i = 0; i < 5; i++) begin
            checkOutput("bp_valid", out_valid, 1'b1);
            checkOutput("bp_data", out_data, toBits(60));
            checkOutput("bp_in_ready", in_ready, 1'b0);
            tick();
        end
        out_ready = 1'b1;
        #1;
        checkOutput("bp_release_ready", in_ready, 1'b1);
        modelAccept(1, 55); tick();
        modelAccept(0, 8); pushExpected(); applyStimulus(1, 8, 2, 1);
        checkOutput("b2b_data", out_data, toBits(63));
        in_valid = 1'b0;
        tick();

        $display("[TB] zero frame length");
        modelAccept(1, -5); pushExpected(); applyStimulus(1, -5, 0, 1);
        in_valid = 1'b0;
        checkOutput("len0_valid", out_valid, 1'b1);
        checkOutput("len0_data", out_data, toBits(-5));
        tick();

        $display("[TB] positive overflow");
        modelAccept(1, 32767); applyStimulus(1, 32767, 3, 1);
        modelAccept(0, 32767); applyStimulus(1, 32767, 3, 1);
        modelAccept(0, 32767); pushExpected(); applyStimulus(1, 32767, 3, 1);
        checkOutput("povf_flag", out_ovf, 1'b1);
`ifdef ADDSUB_ACC_SAT_EN
        checkOutput("povf_data", out_data, toBits(65535));
`else
        checkOutput("povf_data", out_data, toBits(-32771));
`endif
        modelAccept(1, 1); pushExpected(); applyStimulus(1, 1, 1, 1);
        in_valid = 1'b0;
        checkOutput("ovf_cleared", out_ovf, 1'b0);
        tick();

        $display("[TB] negative overflow");
        modelAccept(1, -32768); applyStimulus(1, -32768, 3, 1);
        modelAccept(0, -32768); applyStimulus(1, -32768, 3, 1);
        modelAccept(0, -32768); pushExpected(); applyStimulus(1, -32768, 3, 1);
        in_valid = 1'b0;
        checkOutput("novf_flag", out_ovf, 1'b1);
        tick();

        $display("[TB] reset mid-frame");
        applyStimulus(1, 50, 4, 1);
        applyStimulus(1, 60, 4, 1);
        in_valid = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        checkOutput("mid_rst_valid", out_valid, 1'b0);
        checkOutput("mid_rst_data", out_data, '0);
        modelAccept(1, 1); applyStimulus(1, 1, 4, 1);
        modelAccept(0, 1); applyStimulus(1, 1, 2, 1);
        applyStimulus(0, 1, 2, 1);
        checkOutput("gap_no_valid", out_valid, 1'b0);
        modelAccept(0, 1); applyStimulus(1, 1, 2, 1);
        modelAccept(0, 1); pushExpected(); applyStimulus(1, 1, 2, 1);
        in_valid = 1'b0;
        checkOutput("post_rst_valid", out_valid, 1'b1);
        checkOutput("post_rst_data", out_data, toBits(4));
        tick();

        for (int i = 0; i < 20 && expQ.size() != 0; i++) tick();
        checkOutput("sb_drained", ACC_W'(expQ.size()), '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
